// File: rtl/mag_bin_search.sv
// mag_bin_search: binary search over [req_low, req_hgh] against an external comparator.
// One candidate in flight at a time; outputs depend only on registered state.
module mag_bin_search #(
    parameter int WIDTH = 32,
    parameter int IMPLEMENTATION = 0,
    localparam int CW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [WIDTH-1:0] req_low,
    input  logic [WIDTH-1:0] req_hgh,
    output logic             cmp_vld,
    input  logic             cmp_rdy,
    output logic [WIDTH-1:0] cmp_val,
    input  logic             rsp_vld,
    input  logic             rsp_grt,
    input  logic             rsp_lst,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] res_val,
    output logic             res_fnd,
    output logic             res_err,
    output logic [CW-1:0]    res_cnt
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    if (IMPLEMENTATION != 0) begin : g_bad_impl
        $fatal(1, "mag_bin_search: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d, cand_w;
    logic [WIDTH-1:0] cand_q, cand_d, val_q, val_d, mid;
    logic             fnd_q, fnd_d, err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Bounds carry an extra bit so candidate +/- 1 at the range edges never wraps.
    always_comb begin
        mid    = WIDTH'(lo_q + ((hi_q - lo_q) >> 1));
        cand_w = {1'b0, cand_q};
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cand_d  = cand_q;
        val_d   = val_q;
        fnd_d   = fnd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_vld) begin
                lo_d    = {1'b0, req_low};
                hi_d    = {1'b0, req_hgh};
                cnt_d   = '0;
                fnd_d   = 1'b0;
                err_d   = 1'b0;
                val_d   = req_low;
                state_d = (req_low > req_hgh) ? DONE : ISSUE;
            end
            ISSUE: if (cmp_rdy) begin
                cand_d  = mid;
                cnt_d   = cnt_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: if (rsp_vld) begin
                val_d = cand_q;
                if (rsp_grt && rsp_lst) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!rsp_grt && !rsp_lst) begin
                    fnd_d   = 1'b1;
                    state_d = DONE;
                end else if (rsp_grt) begin
                    hi_d    = (cand_w == lo_q) ? hi_q : cand_w - 1'b1;
                    state_d = (cand_w == lo_q) ? DONE : ISSUE;
                end else begin
                    lo_d    = (cand_w == hi_q) ? lo_q : cand_w + 1'b1;
                    state_d = (cand_w == hi_q) ? DONE : ISSUE;
                end
            end
            DONE: state_d = res_rdy ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            cand_q  <= '0;
            val_q   <= '0;
            fnd_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cand_q  <= cand_d;
            val_q   <= val_d;
            fnd_q   <= fnd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_rdy = state_q == IDLE;
    assign cmp_vld = state_q == ISSUE;
    assign cmp_val = cmp_vld ? mid : '0;
    assign res_vld = state_q == DONE;
    assign res_val = val_q;
    assign res_fnd = fnd_q;
    assign res_err = err_q;
    assign res_cnt = cnt_q;
endmodule

// File: tb/tb_mag_bin_search.sv
// tb_mag_bin_search: directed and stalled searches on an 8-bit instance with a comparator model.
module tb_mag_bin_search;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_vld = 1'b0, cmp_rdy = 1'b0, rsp_vld = 1'b0, rsp_grt = 1'b0, rsp_lst = 1'b0, res_rdy = 1'b0;
    logic [7:0] req_low = '0, req_hgh = '0;
    logic       req_rdy, cmp_vld, res_vld, res_fnd, res_err;
    logic [7:0] cmp_val, res_val;
    logic [3:0] res_cnt;
    int         checks = 0, errors = 0;
    logic [7:0] cand_log[$];
    bit         saw_cmp;
    logic [7:0] got_val;
    logic       got_fnd, got_err;
    logic [3:0] got_cnt;

    mag_bin_search #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_low(req_low), .req_hgh(req_hgh), .cmp_vld(cmp_vld), .cmp_rdy(cmp_rdy),
        .cmp_val(cmp_val), .rsp_vld(rsp_vld), .rsp_grt(rsp_grt), .rsp_lst(rsp_lst),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_val(res_val), .res_fnd(res_fnd),
        .res_err(res_err), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, req_rdy, 1);
        chk({tag, "_cmp_vld"}, cmp_vld, 0);
        chk({tag, "_res_vld"}, res_vld, 0);
        chk({tag, "_cmp_val"}, cmp_val, 0);
        chk({tag, "_res_val"}, res_val, 0);
        chk({tag, "_fnd_err_cnt"}, {res_fnd, res_err, res_cnt}, 0);
    endtask

    function automatic void model(input int lo_i, input int hi_i, input int rf, input int err_at,
                                  output int v, output int f, output int e, output int c);
        int lo = lo_i, hi = hi_i, m;
        c = 0; f = 0; e = 0; v = lo_i;
        if (lo > hi) return;
        while (1) begin
            m = lo + (hi - lo) / 2;
            c++;
            v = m;
            if (c == err_at) begin e = 1; return; end
            if (m == rf) begin f = 1; return; end
            if (m > rf) begin
                if (m == lo) return;
                hi = m - 1;
            end else begin
                if (m == hi) return;
                lo = m + 1;
            end
        end
    endfunction

    // Called just after a falling edge; drives one whole search and returns just after a falling edge.
    task automatic run(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] rf,
                       input int err_at, input bit rnd);
        int issued = 0, dly = 0;
        bit pend = 0, cstall = 0, rstall = 0, done = 0;
        logic [7:0] hcv = '0, hval = '0;
        logic [5:0] hflags = '0;
        cand_log.delete();
        saw_cmp = 0;
        req_low = lo; req_hgh = hi; req_vld = 1'b1;
        chk("req_rdy_idle", req_rdy, 1);
        @(negedge clk);
        req_vld = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            cmp_rdy = 0; rsp_vld = 0; res_rdy = 0;
            rsp_grt = rnd ? 1'($urandom) : 1'b0;
            rsp_lst = rnd ? 1'($urandom) : 1'b0;
            if (cmp_vld) saw_cmp = 1;
            if (res_vld) begin
                chk("req_rdy_in_done", req_rdy, 0);
                if (rstall) begin
                    chk("res_val_stable", res_val, hval);
                    chk("res_flags_stable", {res_fnd, res_err, res_cnt}, hflags);
                end
                if (rnd && $urandom_range(0, 2) == 0) begin
                    rstall = 1; hval = res_val; hflags = {res_fnd, res_err, res_cnt};
                end else begin
                    res_rdy = 1; done = 1;
                    got_val = res_val; got_fnd = res_fnd; got_err = res_err; got_cnt = res_cnt;
                end
            end else if (pend) begin
                if (dly == 0) begin
                    rsp_vld = 1; pend = 0;
                    rsp_grt = (issued == err_at) || (cand_log[$] > rf);
                    rsp_lst = (issued == err_at) || (cand_log[$] < rf);
                end else dly--;
            end else if (cmp_vld) begin
                if (cstall) chk("cmp_val_stable", cmp_val, hcv);
                cstall = 0;
                if (!rnd || $urandom_range(0, 1) == 1) begin
                    cmp_rdy = 1; cand_log.push_back(cmp_val); issued++; pend = 1;
                    dly = rnd ? $urandom_range(0, 5) : 0;
                end else begin
                    cstall = 1; hcv = cmp_val;
                end
            end
            @(negedge clk);
        end
        cmp_rdy = 0; rsp_vld = 0; res_rdy = 0; rsp_grt = 0; rsp_lst = 0;
        if (!done) chk("search_timeout", 0, 1);
        chk("idle_after_result", {req_rdy, res_vld}, 2'b10);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] v, input logic f, input logic e, input logic [3:0] c);
        chk({tag, "_val"}, got_val, v);
        chk({tag, "_fnd"}, got_fnd, f);
        chk({tag, "_err"}, got_err, e);
        chk({tag, "_cnt"}, got_cnt, c);
    endtask

    initial begin
        logic [7:0] exp37[7];
        int mv, mf, me, mc, lo, hi, rf;
        exp37 = '{8'd127, 8'd63, 8'd31, 8'd47, 8'd39, 8'd35, 8'd37};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(8'd0, 8'd255, 8'd37, 0, 0);
        chk_res("ref37", 8'd37, 1, 0, 4'd7);
        chk("ref37_ncand", cand_log.size(), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("ref37_cand%0d", i), cand_log[i], exp37[i]);

        run(8'd0, 8'd255, 8'd255, 0, 0);
        chk_res("ref255", 8'd255, 1, 0, 4'd9);

        run(8'd0, 8'd255, 8'd0, 0, 0);
        chk_res("ref0", 8'd0, 1, 0, 4'd8);

        run(8'd10, 8'd20, 8'd5, 0, 0);
        chk_res("below", 8'd10, 0, 0, 4'd3);
        chk("below_cands", {cand_log[0], cand_log[1], cand_log[2]}, {8'd15, 8'd12, 8'd10});

        run(8'd20, 8'd10, 8'd15, 0, 0);
        chk_res("inverted", 8'd20, 0, 0, 4'd0);
        chk("inverted_no_cmp", saw_cmp, 0);

        run(8'd0, 8'd255, 8'd37, 2, 0);
        chk_res("errrsp", 8'd63, 0, 1, 4'd2);

        for (int k = 0; k < 8; k++) begin
            lo = $urandom_range(0, 200); hi = $urandom_range(lo, 255); rf = $urandom_range(0, 255);
            if (k == 0) begin lo = 0; hi = 255; rf = 200; end
            if (k == 1) begin lo = 50; hi = 60; rf = 90; end
            model(lo, hi, rf, 0, mv, mf, me, mc);
            run(8'(lo), 8'(hi), 8'(rf), 0, 1);
            chk_res($sformatf("rand%0d", k), 8'(mv), 1'(mf), 1'(me), 4'(mc));
        end

        req_low = 8'd0; req_hgh = 8'd255; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; cmp_rdy = 1'b1;
        @(negedge clk);
        cmp_rdy = 1'b0;
        chk("rst_in_wait", {req_rdy, cmp_vld, res_vld}, 3'b000);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n = 1'b1; rsp_vld = 1'b1; rsp_grt = 1'b0; rsp_lst = 1'b0;
        @(negedge clk);
        rsp_vld = 1'b0;
        @(negedge clk);
        chk("late_rsp_ignored", {req_rdy, cmp_vld, res_vld, res_fnd}, 4'b1000);

        run(8'd10, 8'd20, 8'd15, 0, 0);
        chk_res("after_rst", 8'd15, 1, 0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mag_bin_search.md
MAG_BIN_SEARCH -- requirements
Module: mag_bin_search

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the value width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter IMPLEMENTATION, default 0: midpoint = lo + ((hi - lo) >> 1); any other value SHALL be rejected at elaboration with $fatal.
REQ-003 SHALL define a derived width CW = $clog2(WIDTH+2).
REQ-004 clk  input  1  clock; one clock domain, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_vld  input  1  search request valid.
REQ-007 req_rdy  output  1  request accepted when req_vld && req_rdy.
REQ-008 req_low  input  WIDTH  inclusive lower search bound, unsigned.
REQ-009 req_hgh  input  WIDTH  inclusive upper search bound, unsigned.
REQ-010 cmp_vld  output  1  candidate valid toward the external comparator.
REQ-011 cmp_rdy  input  1  comparator accepts the candidate when cmp_vld && cmp_rdy.
REQ-012 cmp_val  output  WIDTH  candidate value.
REQ-013 rsp_vld  input  1  comparator response valid.
REQ-014 rsp_grt  input  1  candidate greater than the hidden reference.
REQ-015 rsp_lst  input  1  candidate less than the hidden reference.
REQ-016 res_vld  output  1  result valid.
REQ-017 res_rdy  input  1  result consumed when res_vld && res_rdy.
REQ-018 res_val  output  WIDTH  final candidate.
REQ-019 res_fnd  output  1  exact match found.
REQ-020 res_err  output  1  inconsistent response (rsp_grt && rsp_lst).
REQ-021 res_cnt  output  CW  number of compares issued.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; req_rdy = (state == IDLE).
REQ-023 IDLE: on request acceptance, lo/hi SHALL load from req_low/req_hgh, count SHALL clear, and next state SHALL be ISSUE; if req_low > req_hgh, next state SHALL instead be DONE with res_fnd=0, res_cnt=0, res_val=req_low, and no compare issued.
REQ-024 ISSUE: cmp_vld=1 and cmp_val=midpoint(lo,hi), held stable until cmp_rdy; on cmp_vld && cmp_rdy, count SHALL increment and next state SHALL be WAIT.
REQ-025 WAIT: rsp_* SHALL be sampled only when rsp_vld=1, and rsp_vld outside WAIT SHALL be ignored; the comparator may respond zero or more cycles after acceptance.
REQ-026 On a sampled response with grt=0 and lst=0: DONE, res_fnd=1, res_val=candidate.
REQ-027 On grt=1 and lst=0: if candidate == lo, DONE with res_fnd=0; else hi = candidate-1, then ISSUE.
REQ-028 On lst=1 and grt=0: if candidate == hi, DONE with res_fnd=0; else lo = candidate+1, then ISSUE.
REQ-029 On grt=1 and lst=1: DONE, res_err=1, res_fnd=0.
REQ-030 Arithmetic SHALL be WIDTH+1 bits internally, so that candidate-1 at 0 and candidate+1 at 2^WIDTH-1 never wrap (covered by REQ-027/028).
REQ-031 On a not-found or error result, res_val SHALL hold the last candidate issued.
REQ-032 DONE: res_vld=1 with res_val/res_fnd/res_err/res_cnt stable until res_rdy; on handshake the next state SHALL be IDLE, and a new request SHALL be accepted no earlier than the following cycle.
REQ-033 Compares per search SHALL not exceed WIDTH+1.
REQ-034 Each state SHALL dwell at least one cycle, so no combinational path SHALL exist from any input to any output.

Reset
REQ-035 While rst_n=0 at a clk edge, state SHALL be IDLE, and req_rdy=1, cmp_vld=0, res_vld=0, cmp_val=0, res_val=0, res_fnd=0, res_err=0, res_cnt=0.
REQ-036 Reset asserted mid-search SHALL abandon the search with no result produced; a response arriving after reset release SHALL be ignored.

Verification (WIDTH=8; comparator model responds 1 cycle after acceptance unless stated)
REQ-037 Range 0..255, ref 37 -> candidates 127,63,31,47,39,35,37; res_fnd=1, res_val=37, res_cnt=7.
REQ-038 Range 0..255, ref 255 -> 9 compares ending at 255, no wrap, res_fnd=1; ref 0 -> 8 compares ending at 0, res_fnd=1.
REQ-039 Range 10..20, ref 5 -> candidates 15,12,10; res_fnd=0, res_val=10, res_cnt=3; range 20..10 -> immediate DONE, res_cnt=0, cmp_vld never asserted.
REQ-040 Comparator returns grt=lst=1 on the 2nd compare -> res_err=1, res_fnd=0, res_cnt=2.
REQ-041 Random cmp_rdy/res_rdy stalls and 0-5 cycle response delay -> cmp_val and result fields stay stable while stalled, and results match a reference model.
REQ-042 rst_n pulsed low while in WAIT -> next cycle IDLE with all outputs at reset values, and a late rsp_vld is ignored.
